// File: rtl/gpr_mp_if.sv
// gpr_mp_if: bundle for the gpr_mp register file.
// One interface carries the decode-side read/allocate signals and the
// write-back signals. The master modport drives requests. The slave
// modport (the register file) returns registered read data and busy flags.
//   ren       per-port read enable; a low bit holds that port's outputs
//   rsn       read indices, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   rsd       registered read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   rs_busy   registered busy flag of each read register
//   wbe       per-port write enable
//   rdn, rdd  write indices and write data, packed like rsn and rsd
//   alloc_en  mark alloc_rdn as having a write in flight
//   alloc_rdn register to allocate
// Handshake: there is no valid/ready pair. Every enabled request is taken
// on the rising edge where it is present, and the block never stalls.
interface gpr_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2
);
  logic [NUM_RD-1:0]            ren;
  logic [NUM_RD*ADDR_WIDTH-1:0] rsn;
  logic [NUM_RD*DATA_WIDTH-1:0] rsd;
  logic [NUM_RD-1:0]            rs_busy;
  logic [NUM_WR-1:0]            wbe;
  logic [NUM_WR*ADDR_WIDTH-1:0] rdn;
  logic [NUM_WR*DATA_WIDTH-1:0] rdd;
  logic                         alloc_en;
  logic [ADDR_WIDTH-1:0]        alloc_rdn;

  modport master (
    output ren, rsn, wbe, rdn, rdd, alloc_en, alloc_rdn,
    input  rsd, rs_busy
  );

  modport slave (
    input  ren, rsn, wbe, rdn, rdd, alloc_en, alloc_rdn,
    output rsd, rs_busy
  );
endinterface

// File: rtl/gpr_mp.sv
// gpr_mp: multi-port general purpose register file with a busy scoreboard.
// It has NUM_RD registered read ports and NUM_WR write-back ports. Register
// 0 can be hardwired to zero (ZERO_REG). A write can be forwarded to a read
// of the same index on the same edge (BYPASS). Each register has a busy bit.
// Decode sets the busy bit by allocating the register, and write-back clears
// it by writing the register.
// Ports:
//   clk     rising-edge clock
//   rstn_h  asynchronous active-low reset; clears data, busy bits and outputs
//   bus     gpr_mp_if slave modport (read, write and allocate signals)
module gpr_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic     clk,
  input  logic     rstn_h,
  gpr_mp_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]        r_mem [DEPTH];
  logic [DEPTH-1:0]             r_busy;
  logic [NUM_RD*DATA_WIDTH-1:0] r_rsd;
  logic [NUM_RD-1:0]            r_rs_busy;

  logic [DATA_WIDTH-1:0]        w_mem_next [DEPTH];
  logic [DEPTH-1:0]             w_busy_next;
  logic [ADDR_WIDTH-1:0]        w_rd_idx  [NUM_RD];
  logic [DATA_WIDTH-1:0]        w_rd_data [NUM_RD];
  logic                         w_rd_busy [NUM_RD];

  // Array contents after this cycle's writes and allocations. Write ports are
  // applied in ascending order, so the higher port wins on an index clash.
  // Allocation is applied after the writes, so a new producer keeps the
  // register busy even when an older producer writes it on the same edge.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) w_mem_next[i] = r_mem[i];
    w_busy_next = r_busy;
    for (int w = 0; w < NUM_WR; w++) begin
      if (bus.wbe[w]) begin
        w_mem_next[bus.rdn[w*ADDR_WIDTH +: ADDR_WIDTH]]  = bus.rdd[w*DATA_WIDTH +: DATA_WIDTH];
        w_busy_next[bus.rdn[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
    end
    if (bus.alloc_en) w_busy_next[bus.alloc_rdn] = 1'b1;
    // Register 0 drops every write and allocation when hardwired to zero.
    if (ZERO_REG != 0) begin
      w_mem_next[0]  = '0;
      w_busy_next[0] = 1'b0;
    end
  end

  // Read selection. With BYPASS, a read sees this cycle's writes.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      w_rd_idx[p] = bus.rsn[p*ADDR_WIDTH +: ADDR_WIDTH];
      if (ZERO_REG != 0 && w_rd_idx[p] == '0) begin
        w_rd_data[p] = '0;
        w_rd_busy[p] = 1'b0;
      end else if (BYPASS != 0) begin
        w_rd_data[p] = w_mem_next[w_rd_idx[p]];
        w_rd_busy[p] = w_busy_next[w_rd_idx[p]];
      end else begin
        w_rd_data[p] = r_mem[w_rd_idx[p]];
        w_rd_busy[p] = r_busy[w_rd_idx[p]];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn_h) begin
    if (!rstn_h) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy    <= '0;
      r_rsd     <= '0;
      r_rs_busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= w_mem_next[i];
      r_busy <= w_busy_next;
      // A port with its read enable low keeps its previous outputs.
      for (int p = 0; p < NUM_RD; p++) begin
        if (bus.ren[p]) begin
          r_rsd[p*DATA_WIDTH +: DATA_WIDTH] <= w_rd_data[p];
          r_rs_busy[p]                      <= w_rd_busy[p];
        end
      end
    end
  end

  assign bus.rsd     = r_rsd;
  assign bus.rs_busy = r_rs_busy;
endmodule

// File: doc/gpr_mp.md
# gpr_mp

Parametrised multi-port general purpose register file for the next core revision. Provides NUM_RD synchronous read ports and NUM_WR write-back ports, optional hardwired zero register, optional same-cycle write-to-read forwarding, and a per-register busy scoreboard for in-flight writes. Sits between decode (read, allocate) and write-back (write, release).

## Interface
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- NUM_RD, 2, read ports (1-4)
- NUM_WR, 2, write ports (1-2)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/allocations
- BYPASS, 1, 1 = same-cycle write forwarded to read outputs

- clk  in  1  clock; all state updates on rising edge
- rstn_h  in  1  asynchronous active-low reset
- ren  in  NUM_RD  per-port read enable; low holds that port's outputs
- rsn  in  NUM_RD*ADDR_WIDTH  read indices, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- rsd  out  NUM_RD*DATA_WIDTH  registered read data, same packing
- rs_busy  out  NUM_RD  registered busy flag of the read register
- wbe  in  NUM_WR  per-port write enable
- rdn  in  NUM_WR*ADDR_WIDTH  write indices
- rdd  in  NUM_WR*DATA_WIDTH  write data
- alloc_en  in  1  mark alloc_rdn as having a pending write
- alloc_rdn  in  ADDR_WIDTH  register to allocate

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH array plus busy bit per register.
- Write: wbe[w] writes rdd[w] to rdn[w]. Two ports same index same cycle: port 1 wins. ZERO_REG=1: writes to index 0 dropped.
- Release: any enabled write to index r clears busy[r].
- Allocate: alloc_en sets busy[alloc_rdn]. Allocate and write to same register same cycle: busy ends 1 (new producer wins), data still written. ZERO_REG=1: allocation of 0 ignored, busy[0] always 0.
- Next-state view: data_next/busy_next = array contents after this cycle's writes/allocations.
- Read port p, ren[p]=1: rsd[p] <= BYPASS ? data_next[rsn[p]] : current[rsn[p]]; rs_busy[p] <= BYPASS ? busy_next[rsn[p]] : busy[rsn[p]]. ZERO_REG=1 and rsn[p]=0: rsd[p] <= 0, rs_busy[p] <= 0.
- ren[p]=0: rsd[p], rs_busy[p] hold; array updates proceed.
- Ports independent; all ports may read the same index.

## Timing
- Reset (rstn_h low, asynchronous, immediate): all registers 0, all busy 0, rsd 0, rs_busy 0. Held while low; inputs ignored.
- Deassertion: first rising edge with rstn_h high performs normal operation.
- Reset mid-operation: pending writes/allocations in that cycle discarded; scoreboard fully cleared.
- Write latency: write at edge N visible in array after edge N. Read issued at edge N returns data after edge N (one-cycle read latency).
- BYPASS=1: read and write same index same edge returns new data; BYPASS=0 returns old data, new data on next read.
- No handshake stalls; block accepts every request every cycle.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert rstn_h low mid-cycle -> rsd, rs_busy 0 immediately; read r5 after release -> 0x00000000.
- Basic: write 0x12345678 to r7 at edge N, read r7 on port 0 at N+1 -> rsd[0]=0x12345678 after N+1; port 1 reads r7 simultaneously -> same value.
- Bypass: r3=0x1, same edge write 0xA5A5A5A5 and read r3 -> BYPASS=1 gives 0xA5A5A5A5; BYPASS=0 gives 0x1.
- Zero/conflict: write 0xFFFFFFFF to r0 -> read 0 (ZERO_REG=1); both write ports target r9 with 0x11/0x22 -> r9=0x22.
- Scoreboard: alloc r4 -> rs_busy 1 on next read; write r4 0x44 -> busy 0, rsd 0x44; alloc and write r4 same edge -> busy 1, data 0x44.
- Hold: ren[0]=0 while r7 rewritten to 0x99 -> rsd[0] keeps prior value until ren[0]=1.
